vend_controller: RTL and testbench
==================================

# vend_controller

Multi-slot vending sequencer that sits between the coin acceptor, the selection keypad, and the dispense/change mechanics. It accumulates credit in Rs, validates selections against price and per-slot stock, and drives the dispense motor through a request/done handshake with timeout. It then returns change one Rs5 coin at a time through a request/ack handshake. It supersedes single-product vend logic for multi-product cabinets.

## Interface
- NUM_SLOTS, 4: product slots; slot index width is 2
- PRICE, 15: price in Rs, must be a multiple of 5 and ≤ MAX_CREDIT
- MAX_CREDIT, 30: credit ceiling in Rs
- STOCK_INIT, 8: per-slot stock after reset or restock; fits STOCK_W
- STOCK_W, 4: stock counter width
- TIMEOUT, 255: maximum cycles to wait for disp_done
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-low
- coin  in  2  01 = Rs5, 10 = Rs10, 00/11 = no coin; one-cycle pulse per coin
- sel_valid  in  1  selection strobe
- sel_slot  in  2  selected slot
- cancel  in  1  request refund of all credit
- restock  in  1  reload all slots to STOCK_INIT
- disp_done  in  1  dispense complete
- chg_ack  in  1  one Rs5 coin ejected
- disp_req  out  1  dispense request, level
- disp_slot  out  2  slot being dispensed
- chg_req  out  1  change request, level
- credit  out  6  current credit in Rs
- sold_out  out  NUM_SLOTS  bit i set when stock[i] == 0
- coin_rej  out  1  pulse: coin not accepted
- sel_rej  out  1  pulse: selection refused
- fault  out  1  pulse: dispense timeout
- busy  out  1  high in VEND and REFUND

## Operation
- States:
  - IDLE: credit == 0.
    - A coin adds its value and the block goes to COLLECT.
    - restock is honoured here only and reloads every stock counter.
    - sel_valid gives sel_rej.
    - cancel is ignored.
  - COLLECT: coins add their value.
    - Accepted selection: sel_valid, credit ≥ PRICE, stock[sel_slot] != 0. credit -= PRICE, latch disp_slot, go to VEND.
    - Refused selection: sel_valid with credit < PRICE or slot empty. sel_rej pulses, state unchanged.
    - cancel: go to REFUND.
  - VEND: disp_req held high.
    - On disp_done: stock[disp_slot] -= 1, timer cleared. Go to REFUND if credit > 0, else IDLE.
    - Timer reaches TIMEOUT with no disp_done: credit += PRICE (restored), stock unchanged, fault pulses, go to REFUND.
  - REFUND: chg_req held high.
    - Each cycle with chg_ack: credit -= 5.
    - The ack that brings credit to 0 returns the block to IDLE, and chg_req drops the same edge.
- Coin acceptance:
  - A coin whose value would push credit above MAX_CREDIT is refused with coin_rej, and credit is unchanged.
  - Coins arriving in VEND or REFUND are always refused with coin_rej.
  - coin = 11 is treated as no coin, with no coin_rej.
- Simultaneous events in COLLECT (same cycle):
  - cancel takes priority over sel_valid; the selection is dropped and sel_rej does not pulse.
  - A coin arriving with cancel or an accepted selection is still added, subject to the cap, computed on the post-selection credit. Example: credit 15 + Rs10 + accepted selection → credit 10.
  - The acceptance test for a selection uses pre-coin credit.
- Inputs are ignored outside their states: disp_done outside VEND, chg_ack outside REFUND, restock outside IDLE.
- Credit arithmetic is unsigned 6-bit and never goes below 0 or above MAX_CREDIT.
- sold_out is combinational from the stock registers.

## Timing
- All outputs are registered except sold_out.
- State, credit, and pulses update on the clk edge that samples the causing input and are visible the following cycle.
- Latencies:
  - Accepted sel_valid at edge N → disp_req high from N+1.
  - disp_done at edge M → disp_req low from M+1, and stock decremented at M+1.
- Timeout: the timer counts VEND cycles starting at 1 on the VEND entry cycle. fault asserts the cycle after the count reaches TIMEOUT without disp_done.
- Pulses (coin_rej, sel_rej, fault) are exactly one cycle wide.
- Reset (rst low at an edge):
  - Registers: state IDLE, credit 0, every stock counter STOCK_INIT, timer 0.
  - Outputs: disp_req 0, chg_req 0, coin_rej, sel_rej, fault all 0, busy 0, disp_slot 0.
  - Reset mid-VEND or mid-REFUND discards credit with no refund.

## Test plan
- Coin Rs10, Rs5, then sel slot 2 → credit 10, then 15. disp_req high next cycle with disp_slot 2 and credit 0. disp_done → stock[2] = 7, return to IDLE, no chg_req.
- Coins Rs10, Rs10, sel slot 0, disp_done → credit 5 during VEND. Then REFUND: chg_req, one chg_ack → credit 0, IDLE.
- Credit 25, then Rs10 → coin_rej, credit stays 25. cancel → five chg_req/chg_ack cycles, then IDLE.
- Drain slot 1 through 8 vends → sold_out[1] = 1. A 9th selection with credit 15 gives sel_rej. restock in IDLE → sold_out = 0 and every stock counter back at STOCK_INIT.
- Credit 15, sel slot 3, disp_done withheld 255 cycles → fault, credit back to 15, stock[3] = 8, three chg_ack refunds.
- Credit 15, sel slot 0 and Rs10 in the same cycle → credit 10, VEND. Assert rst low mid-VEND → all outputs 0 and credit 0 on the following cycle.

Source files
------------

// File: rtl/vend_controller.sv
// Multi-slot vending sequencer: accumulates coin credit, validates selections
// against price and per-slot stock, runs the dispense handshake with a timeout,
// then pays change back one Rs5 coin at a time.
module vend_controller #(
  parameter int NUM_SLOTS  = 4,
  parameter int PRICE      = 15,
  parameter int MAX_CREDIT = 30,
  parameter int STOCK_INIT = 8,
  parameter int STOCK_W    = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [1:0]                   coin,
  input  logic                         sel_valid,
  input  logic [$clog2(NUM_SLOTS)-1:0] sel_slot,
  input  logic                         cancel,
  input  logic                         restock,
  input  logic                         disp_done,
  input  logic                         chg_ack,
  output logic                         disp_req,
  output logic [$clog2(NUM_SLOTS)-1:0] disp_slot,
  output logic                         chg_req,
  output logic [5:0]                   credit,
  output logic [NUM_SLOTS-1:0]         sold_out,
  output logic                         coin_rej,
  output logic                         sel_rej,
  output logic                         fault,
  output logic                         busy
);

  localparam int SLOT_W = $clog2(NUM_SLOTS);
  localparam int TMR_W  = $clog2(TIMEOUT + 1);

  localparam logic [5:0]         PRICE_C      = 6'(PRICE);
  localparam logic [6:0]         MAX_C        = 7'(MAX_CREDIT);
  localparam logic [STOCK_W-1:0] STOCK_INIT_C = STOCK_W'(STOCK_INIT);
  localparam logic [TMR_W-1:0]   TIMEOUT_C    = TMR_W'(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_VEND, S_REFUND} state_t;

  state_t              state_q, state_d;
  logic [5:0]          credit_q, credit_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [STOCK_W-1:0]  stock_q [NUM_SLOTS];
  logic [STOCK_W-1:0]  stock_d [NUM_SLOTS];
  logic                disp_req_q, chg_req_q, busy_q;
  logic                coin_rej_q, coin_rej_d;
  logic                sel_rej_q, sel_rej_d;
  logic                fault_q, fault_d;

  logic [6:0]          coin_val;
  logic [5:0]          base;
  logic [6:0]          sum;

  // Rs value of the coin acceptor code; 00 and 11 both mean no coin.
  function automatic logic [6:0] coin_value(input logic [1:0] c);
    case (c)
      2'b01:   return 7'd5;
      2'b10:   return 7'd10;
      default: return 7'd0;
    endcase
  endfunction

  // Next-state, credit, stock and pulse decisions for the current state.
  always_comb begin
    state_d    = state_q;
    credit_d   = credit_q;
    timer_d    = timer_q;
    slot_d     = slot_q;
    coin_rej_d = 1'b0;
    sel_rej_d  = 1'b0;
    fault_d    = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) stock_d[i] = stock_q[i];
    coin_val   = coin_value(coin);
    base       = credit_q;
    sum        = 7'd0;

    case (state_q)
      S_IDLE: begin
        if (coin_val != 7'd0) begin
          sum = {1'b0, credit_q} + coin_val;
          if (sum <= MAX_C) begin
            credit_d = sum[5:0];
            state_d  = S_COLLECT;
          end else begin
            coin_rej_d = 1'b1;
          end
        end
        if (restock) begin
          for (int i = 0; i < NUM_SLOTS; i++) stock_d[i] = STOCK_INIT_C;
        end
        if (sel_valid) sel_rej_d = 1'b1;
      end

      S_COLLECT: begin
        // Selection is judged on pre-coin credit; a same-cycle coin lands on
        // whatever credit remains after the selection.
        if (cancel) begin
          state_d = S_REFUND;
        end else if (sel_valid) begin
          if (credit_q >= PRICE_C && stock_q[sel_slot] != '0) begin
            base    = credit_q - PRICE_C;
            slot_d  = sel_slot;
            timer_d = TMR_W'(1);
            state_d = S_VEND;
          end else begin
            sel_rej_d = 1'b1;
          end
        end
        credit_d = base;
        if (coin_val != 7'd0) begin
          sum = {1'b0, base} + coin_val;
          if (sum <= MAX_C) credit_d = sum[5:0];
          else              coin_rej_d = 1'b1;
        end
      end

      S_VEND: begin
        if (coin_val != 7'd0) coin_rej_d = 1'b1;
        if (disp_done) begin
          if (stock_q[slot_q] != '0) stock_d[slot_q] = stock_q[slot_q] - 1'b1;
          timer_d = '0;
          state_d = (credit_q != 6'd0) ? S_REFUND : S_IDLE;
        end else if (timer_q == TIMEOUT_C) begin
          // Mechanism never confirmed: give the price back and refund it all.
          credit_d = credit_q + PRICE_C;
          fault_d  = 1'b1;
          timer_d  = '0;
          state_d  = S_REFUND;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      S_REFUND: begin
        if (coin_val != 7'd0) coin_rej_d = 1'b1;
        if (chg_ack) begin
          if (credit_q <= 6'd5) begin
            credit_d = 6'd0;
            state_d  = S_IDLE;
          end else begin
            credit_d = credit_q - 6'd5;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State, datapath and registered outputs; reset discards any credit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      credit_q   <= 6'd0;
      timer_q    <= '0;
      slot_q     <= '0;
      disp_req_q <= 1'b0;
      chg_req_q  <= 1'b0;
      busy_q     <= 1'b0;
      coin_rej_q <= 1'b0;
      sel_rej_q  <= 1'b0;
      fault_q    <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) stock_q[i] <= STOCK_INIT_C;
    end else begin
      state_q    <= state_d;
      credit_q   <= credit_d;
      timer_q    <= timer_d;
      slot_q     <= slot_d;
      disp_req_q <= (state_d == S_VEND);
      chg_req_q  <= (state_d == S_REFUND);
      busy_q     <= (state_d == S_VEND) || (state_d == S_REFUND);
      coin_rej_q <= coin_rej_d;
      sel_rej_q  <= sel_rej_d;
      fault_q    <= fault_d;
      for (int i = 0; i < NUM_SLOTS; i++) stock_q[i] <= stock_d[i];
    end
  end

  // Sold-out flags follow the stock counters directly.
  always_comb begin
    sold_out = '0;
    for (int i = 0; i < NUM_SLOTS; i++) sold_out[i] = (stock_q[i] == '0);
  end

  assign disp_req  = disp_req_q;
  assign disp_slot = slot_q;
  assign chg_req   = chg_req_q;
  assign credit    = credit_q;
  assign coin_rej  = coin_rej_q;
  assign sel_rej   = sel_rej_q;
  assign fault     = fault_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_vend_controller.sv
// Bench for vend_controller: directed scenarios plus randomized vending
// sessions checked against a credit/stock model kept in the bench.
module tb_vend_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] coin = 2'b00;
  logic       sel_valid = 1'b0;
  logic [1:0] sel_slot = 2'b00;
  logic       cancel = 1'b0;
  logic       restock = 1'b0;
  logic       disp_done = 1'b0;
  logic       chg_ack = 1'b0;
  logic       disp_req;
  logic [1:0] disp_slot;
  logic       chg_req;
  logic [5:0] credit;
  logic [3:0] sold_out;
  logic       coin_rej, sel_rej, fault, busy;

  int n_chk = 0;
  int n_fail = 0;
  int m_stock [4];

  vend_controller dut (
    .clk(clk), .rst(rst), .coin(coin), .sel_valid(sel_valid), .sel_slot(sel_slot),
    .cancel(cancel), .restock(restock), .disp_done(disp_done), .chg_ack(chg_ack),
    .disp_req(disp_req), .disp_slot(disp_slot), .chg_req(chg_req), .credit(credit),
    .sold_out(sold_out), .coin_rej(coin_rej), .sel_rej(sel_rej), .fault(fault), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic int cval(input logic [1:0] c);
    return (c == 2'b01) ? 5 : (c == 2'b10) ? 10 : 0;
  endfunction

  function automatic logic [3:0] exp_sold();
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = (m_stock[i] == 0);
    return r;
  endfunction

  task automatic restock_model();
    for (int i = 0; i < 4; i++) m_stock[i] = 8;
  endtask

  task automatic do_coin(input logic [1:0] c);
    coin = c; cyc(); coin = 2'b00;
  endtask

  task automatic do_sel(input logic [1:0] s);
    sel_valid = 1'b1; sel_slot = s; cyc(); sel_valid = 1'b0;
  endtask

  task automatic do_done();
    disp_done = 1'b1; cyc(); disp_done = 1'b0;
  endtask

  task automatic do_cancel();
    cancel = 1'b1; cyc(); cancel = 1'b0;
  endtask

  // Acks change coins while chg_req is up; bounded so a stuck DUT ends the loop.
  task automatic do_refund(output int acks, input int gap);
    acks = 0;
    while (chg_req === 1'b1 && acks < 12) begin
      repeat ($urandom_range(gap)) cyc();
      chg_ack = 1'b1; cyc(); chg_ack = 1'b0;
      acks++;
    end
  endtask

  task automatic test_reset();
    coin = 2'b10;
    cyc(); cyc();
    coin = 2'b00;
    restock_model();
    n_chk++; if ({disp_req, chg_req, coin_rej, sel_rej, fault, busy} !== 6'b0) begin n_fail++; $display("FAIL reset_ctl: got %b expected 000000", {disp_req, chg_req, coin_rej, sel_rej, fault, busy}); end
    n_chk++; if (credit !== 6'd0) begin n_fail++; $display("FAIL reset_credit: got %0d expected 0", credit); end
    n_chk++; if (disp_slot !== 2'd0) begin n_fail++; $display("FAIL reset_slot: got %0d expected 0", disp_slot); end
    n_chk++; if (sold_out !== 4'b0) begin n_fail++; $display("FAIL reset_sold_out: got %b expected 0000", sold_out); end
    rst = 1'b1;
    cyc();
  endtask

  task automatic test_idle();
    do_sel(2'd1);
    n_chk++; if (sel_rej !== 1'b1) begin n_fail++; $display("FAIL idle_sel_rej: got %b expected 1", sel_rej); end
    cyc();
    n_chk++; if (sel_rej !== 1'b0) begin n_fail++; $display("FAIL idle_sel_rej_width: got %b expected 0", sel_rej); end
    do_cancel();
    n_chk++; if ({chg_req, busy} !== 2'b00) begin n_fail++; $display("FAIL idle_cancel: got %b expected 00", {chg_req, busy}); end
    do_coin(2'b11);
    n_chk++; if (coin_rej !== 1'b0 || credit !== 6'd0) begin n_fail++; $display("FAIL idle_coin11: got rej=%b credit=%0d expected rej=0 credit=0", coin_rej, credit); end
  endtask

  task automatic test_basic_vend();
    do_coin(2'b10);
    n_chk++; if (credit !== 6'd10) begin n_fail++; $display("FAIL basic_credit10: got %0d expected 10", credit); end
    do_coin(2'b01);
    n_chk++; if (credit !== 6'd15) begin n_fail++; $display("FAIL basic_credit15: got %0d expected 15", credit); end
    do_sel(2'd2);
    n_chk++; if (disp_req !== 1'b1 || disp_slot !== 2'd2 || credit !== 6'd0 || busy !== 1'b1) begin n_fail++; $display("FAIL basic_vend: got req=%b slot=%0d credit=%0d busy=%b expected 1/2/0/1", disp_req, disp_slot, credit, busy); end
    cyc();
    n_chk++; if (disp_req !== 1'b1) begin n_fail++; $display("FAIL basic_req_hold: got %b expected 1", disp_req); end
    do_done();
    m_stock[2]--;
    n_chk++; if ({disp_req, chg_req, busy} !== 3'b000 || credit !== 6'd0) begin n_fail++; $display("FAIL basic_done: got req/chg/busy=%b credit=%0d expected 000/0", {disp_req, chg_req, busy}, credit); end
  endtask

  task automatic test_change();
    do_coin(2'b10); do_coin(2'b10);
    n_chk++; if (credit !== 6'd20) begin n_fail++; $display("FAIL change_credit20: got %0d expected 20", credit); end
    do_sel(2'd0);
    n_chk++; if (credit !== 6'd5 || disp_req !== 1'b1) begin n_fail++; $display("FAIL change_vend: got credit=%0d req=%b expected 5/1", credit, disp_req); end
    do_coin(2'b01);
    n_chk++; if (coin_rej !== 1'b1 || credit !== 6'd5) begin n_fail++; $display("FAIL change_vend_coin: got rej=%b credit=%0d expected 1/5", coin_rej, credit); end
    chg_ack = 1'b1; cyc(); chg_ack = 1'b0;
    n_chk++; if (coin_rej !== 1'b0 || credit !== 6'd5 || disp_req !== 1'b1) begin n_fail++; $display("FAIL change_vend_ack: got rej=%b credit=%0d req=%b expected 0/5/1", coin_rej, credit, disp_req); end
    do_done();
    m_stock[0]--;
    n_chk++; if (chg_req !== 1'b1 || disp_req !== 1'b0 || busy !== 1'b1 || credit !== 6'd5) begin n_fail++; $display("FAIL change_refund: got chg=%b req=%b busy=%b credit=%0d expected 1/0/1/5", chg_req, disp_req, busy, credit); end
    chg_ack = 1'b1; cyc(); chg_ack = 1'b0;
    n_chk++; if (chg_req !== 1'b0 || busy !== 1'b0 || credit !== 6'd0) begin n_fail++; $display("FAIL change_idle: got chg=%b busy=%b credit=%0d expected 0/0/0", chg_req, busy, credit); end
  endtask

  task automatic test_cap_cancel();
    int exp;
    do_coin(2'b10); do_coin(2'b10); do_coin(2'b01);
    do_coin(2'b10);
    n_chk++; if (coin_rej !== 1'b1 || credit !== 6'd25) begin n_fail++; $display("FAIL cap_reject: got rej=%b credit=%0d expected 1/25", coin_rej, credit); end
    cyc();
    n_chk++; if (coin_rej !== 1'b0) begin n_fail++; $display("FAIL cap_rej_width: got %b expected 0", coin_rej); end
    do_cancel();
    n_chk++; if (chg_req !== 1'b1 || credit !== 6'd25) begin n_fail++; $display("FAIL cap_cancel: got chg=%b credit=%0d expected 1/25", chg_req, credit); end
    for (int i = 1; i <= 5; i++) begin
      cyc();
      n_chk++; if (credit !== 6'(30 - 5 * i)) begin n_fail++; $display("FAIL cap_no_ack_hold: got %0d expected %0d", credit, 30 - 5 * i); end
      chg_ack = 1'b1; cyc(); chg_ack = 1'b0;
      exp = 25 - 5 * i;
      n_chk++; if (credit !== 6'(exp) || chg_req !== (i < 5)) begin n_fail++; $display("FAIL cap_ack%0d: got credit=%0d chg=%b expected %0d/%b", i, credit, chg_req, exp, (i < 5)); end
    end
  endtask

  task automatic test_sold_out_restock();
    int acks;
    for (int i = 0; i < 8; i++) begin
      do_coin(2'b10); do_coin(2'b01); do_sel(2'd1); do_done();
      m_stock[1]--;
    end
    n_chk++; if (sold_out !== exp_sold()) begin n_fail++; $display("FAIL drain_sold_out: got %b expected %b", sold_out, exp_sold()); end
    do_coin(2'b10); do_coin(2'b01); do_sel(2'd1);
    n_chk++; if (sel_rej !== 1'b1 || credit !== 6'd15 || disp_req !== 1'b0) begin n_fail++; $display("FAIL drain_sel_rej: got rej=%b credit=%0d req=%b expected 1/15/0", sel_rej, credit, disp_req); end
    restock = 1'b1; cyc(); restock = 1'b0;
    n_chk++; if (sold_out !== exp_sold() || sel_rej !== 1'b0) begin n_fail++; $display("FAIL restock_collect: got sold=%b rej=%b expected %b/0", sold_out, sel_rej, exp_sold()); end
    do_cancel();
    do_refund(acks, 1);
    n_chk++; if (acks != 3 || credit !== 6'd0) begin n_fail++; $display("FAIL drain_refund: got acks=%0d credit=%0d expected 3/0", acks, credit); end
    restock = 1'b1; cyc(); restock = 1'b0;
    restock_model();
    n_chk++; if (sold_out !== 4'b0000) begin n_fail++; $display("FAIL restock_idle: got %b expected 0000", sold_out); end
  endtask

  task automatic test_timeout();
    int cnt, drop, acks;
    do_coin(2'b10); do_coin(2'b01); do_sel(2'd3);
    cnt = 0; drop = 0;
    while (fault !== 1'b1 && cnt < 300) begin
      cyc(); cnt++;
      if (fault !== 1'b1 && disp_req !== 1'b1) drop++;
    end
    n_chk++; if (cnt != 255 || drop != 0) begin n_fail++; $display("FAIL timeout_cycles: got %0d cycles drops=%0d expected 255/0", cnt, drop); end
    n_chk++; if (credit !== 6'd15 || chg_req !== 1'b1 || disp_req !== 1'b0) begin n_fail++; $display("FAIL timeout_restore: got credit=%0d chg=%b req=%b expected 15/1/0", credit, chg_req, disp_req); end
    do_done();
    n_chk++; if (fault !== 1'b0 || credit !== 6'd15 || sold_out !== exp_sold()) begin n_fail++; $display("FAIL timeout_after: got fault=%b credit=%0d sold=%b expected 0/15/%b", fault, credit, sold_out, exp_sold()); end
    do_refund(acks, 2);
    n_chk++; if (acks != 3 || busy !== 1'b0) begin n_fail++; $display("FAIL timeout_refund: got acks=%0d busy=%b expected 3/0", acks, busy); end
  endtask

  task automatic test_priority();
    int acks;
    do_coin(2'b10);
    sel_valid = 1'b1; sel_slot = 2'd2; coin = 2'b01; cyc();
    sel_valid = 1'b0; coin = 2'b00;
    n_chk++; if (sel_rej !== 1'b1 || credit !== 6'd15 || disp_req !== 1'b0) begin n_fail++; $display("FAIL precoin_sel: got rej=%b credit=%0d req=%b expected 1/15/0", sel_rej, credit, disp_req); end
    cancel = 1'b1; sel_valid = 1'b1; sel_slot = 2'd0; coin = 2'b01; cyc();
    cancel = 1'b0; sel_valid = 1'b0; coin = 2'b00;
    n_chk++; if (chg_req !== 1'b1 || credit !== 6'd20 || sel_rej !== 1'b0 || disp_req !== 1'b0) begin n_fail++; $display("FAIL cancel_priority: got chg=%b credit=%0d rej=%b req=%b expected 1/20/0/0", chg_req, credit, sel_rej, disp_req); end
    do_refund(acks, 0);
    n_chk++; if (acks != 4 || credit !== 6'd0) begin n_fail++; $display("FAIL cancel_refund: got acks=%0d credit=%0d expected 4/0", acks, credit); end
  endtask

  task automatic test_reset_mid_vend();
    do_coin(2'b10); do_coin(2'b01);
    sel_valid = 1'b1; sel_slot = 2'd3; coin = 2'b10; cyc();
    sel_valid = 1'b0; coin = 2'b00;
    n_chk++; if (credit !== 6'd10 || disp_req !== 1'b1 || disp_slot !== 2'd3 || coin_rej !== 1'b0) begin n_fail++; $display("FAIL sel_with_coin: got credit=%0d req=%b slot=%0d rej=%b expected 10/1/3/0", credit, disp_req, disp_slot, coin_rej); end
    rst = 1'b0; cyc(); rst = 1'b1;
    restock_model();
    n_chk++; if ({disp_req, chg_req, coin_rej, sel_rej, fault, busy} !== 6'b0 || credit !== 6'd0 || disp_slot !== 2'd0) begin n_fail++; $display("FAIL mid_vend_reset: got ctl=%b credit=%0d slot=%0d expected 000000/0/0", {disp_req, chg_req, coin_rej, sel_rej, fault, busy}, credit, disp_slot); end
  endtask

  // Random sessions: coins, then cancel or select (optionally with a coin),
  // dispense after a random delay, and change paid with random ack gaps.
  task automatic test_random();
    int m_credit, post, v, acks, slot, d;
    logic [1:0] c;
    logic exp_rej, jc;
    for (int s = 0; s < 80; s++) begin
      if ($urandom_range(7) == 0) begin
        restock = 1'b1; cyc(); restock = 1'b0;
        restock_model();
      end
      m_credit = 0;
      for (int k = 0; k < int'($urandom_range(1, 5)); k++) begin
        c = 2'($urandom_range(3));
        v = cval(c);
        exp_rej = (v > 0) && (m_credit + v > 30);
        if (v > 0 && !exp_rej) m_credit += v;
        do_coin(c);
        n_chk++; if (coin_rej !== exp_rej || credit !== 6'(m_credit)) begin n_fail++; $display("FAIL rnd_coin s%0d: got rej=%b credit=%0d expected %b/%0d", s, coin_rej, credit, exp_rej, m_credit); end
      end
      slot = $urandom_range(3);
      if (m_credit == 0) begin
        do_sel(2'(slot));
        n_chk++; if (sel_rej !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL rnd_idle_sel s%0d: got rej=%b busy=%b expected 1/0", s, sel_rej, busy); end
      end else if ($urandom_range(3) == 0) begin
        do_cancel();
        do_refund(acks, 3);
        n_chk++; if (acks != m_credit / 5 || credit !== 6'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL rnd_cancel s%0d: got acks=%0d credit=%0d expected %0d/0", s, acks, credit, m_credit / 5); end
      end else begin
        c = $urandom_range(1) ? 2'($urandom_range(1, 2)) : 2'b00;
        v = cval(c);
        sel_valid = 1'b1; sel_slot = 2'(slot); coin = c; cyc();
        sel_valid = 1'b0; coin = 2'b00;
        if (m_credit >= 15 && m_stock[slot] > 0) begin
          post = m_credit - 15;
          exp_rej = (v > 0) && (post + v > 30);
          if (v > 0 && !exp_rej) post += v;
          n_chk++; if (disp_req !== 1'b1 || disp_slot !== 2'(slot) || credit !== 6'(post) || coin_rej !== exp_rej || sel_rej !== 1'b0) begin n_fail++; $display("FAIL rnd_accept s%0d: got req=%b slot=%0d credit=%0d rej=%b/%b expected 1/%0d/%0d/%b/0", s, disp_req, disp_slot, credit, coin_rej, sel_rej, slot, post, exp_rej); end
          d = $urandom_range(12);
          for (int k = 0; k < d; k++) begin
            jc = 1'($urandom_range(1));
            coin = jc ? 2'b01 : 2'b00; cyc(); coin = 2'b00;
            n_chk++; if (coin_rej !== jc || disp_req !== 1'b1 || credit !== 6'(post)) begin n_fail++; $display("FAIL rnd_vend_wait s%0d: got rej=%b req=%b credit=%0d expected %b/1/%0d", s, coin_rej, disp_req, credit, jc, post); end
          end
          do_done();
          m_stock[slot]--;
          n_chk++; if (chg_req !== (post > 0) || disp_req !== 1'b0) begin n_fail++; $display("FAIL rnd_done s%0d: got chg=%b req=%b expected %b/0", s, chg_req, disp_req, (post > 0)); end
          do_refund(acks, 3);
          n_chk++; if (acks != post / 5 || credit !== 6'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL rnd_change s%0d: got acks=%0d credit=%0d expected %0d/0", s, acks, credit, post / 5); end
        end else begin
          exp_rej = (v > 0) && (m_credit + v > 30);
          if (v > 0 && !exp_rej) m_credit += v;
          n_chk++; if (sel_rej !== 1'b1 || disp_req !== 1'b0 || credit !== 6'(m_credit) || coin_rej !== exp_rej) begin n_fail++; $display("FAIL rnd_refuse s%0d: got rej=%b req=%b credit=%0d crej=%b expected 1/0/%0d/%b", s, sel_rej, disp_req, credit, coin_rej, m_credit, exp_rej); end
          do_cancel();
          do_refund(acks, 3);
          n_chk++; if (acks != m_credit / 5 || credit !== 6'd0) begin n_fail++; $display("FAIL rnd_refuse_refund s%0d: got acks=%0d credit=%0d expected %0d/0", s, acks, credit, m_credit / 5); end
        end
      end
      n_chk++; if (sold_out !== exp_sold()) begin n_fail++; $display("FAIL rnd_sold_out s%0d: got %b expected %b", s, sold_out, exp_sold()); end
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_basic_vend();
    test_change();
    test_cap_cancel();
    test_sold_out_restock();
    test_timeout();
    test_priority();
    test_reset_mid_vend();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
